mb_bps_gen: RTL and testbench
=============================

# mb_bps_gen

Programmable, parametrised baud-rate and bit-timing generator for the Modbus UART path. It replaces the fixed-divisor bit sampler with three tick outputs:
- a run-time loadable divisor;
- an oversampling tick phase-locked to each bit;
- a mid-bit sample tick and an end-of-bit tick.

A frame-position counter drives both the RX and TX serialisers.

## Interface
Parameters:
- CLK_FRQ, 50_000_000: system clock frequency, Hz.
- BPS_DEF, 115200: baud rate after reset.
- DIV_W, 16: divisor register width, bits.
- OVS, 16: oversample ticks per bit, power of two, 4..32.
- FRAME_BITS, 10: bits per frame (start + data + parity + stop), 2..15.

Ports:
- clk, in, 1: system clock; all logic on its rising edge.
- rst, in, 1: reset, synchronous, active-high.
- bps_start, in, 1: level; high = run bit timing, low = stop and clear.
- cfg_we, in, 1: divisor write strobe.
- cfg_div, in, DIV_W: new divisor (clk cycles per bit).
- busy, out, 1: generator running.
- ovs_tick, out, 1: one-cycle pulse, OVS per bit.
- mid_tick, out, 1: one-cycle pulse at half-bit.
- bit_tick, out, 1: one-cycle pulse at end of bit.
- bit_idx, out, 4: index of bit in progress, 0..FRAME_BITS-1.
- frame_done, out, 1: one-cycle pulse with the last bit_tick of a frame.
- cfg_err, out, 1: one-cycle pulse, rejected divisor write.

## Operation
- div register: reset value CLK_FRQ/BPS_DEF (434 at the defaults).
- div write: cfg_we=1 with busy=0 and cfg_div >= 2*OVS loads div next cycle.
  - Writing while busy=1, or with cfg_div < 2*OVS, leaves div unchanged and pulses cfg_err the next cycle.
- ovs_div = div / OVS (floor), computed combinationally from div, so ovs_div >= 2.
- Idle (busy=0): bps_cnt=0, ovs_cnt=0, ovs_num=0, bit_idx=0, all ticks low.
- Run: bps_start=1 sampled while idle sets busy=1; bps_cnt counts 0..div-1, wrapping to 0.
- bit_tick fires one cycle after the cycle with bps_cnt==div-1. bit_idx advances in the same cycle bit_tick is high, wrapping FRAME_BITS-1 -> 0. frame_done is high on that wrapping bit_tick.
- mid_tick fires one cycle after the cycle with bps_cnt==div>>1.
- ovs_cnt counts 0..ovs_div-1 and fires ovs_tick one cycle after ovs_cnt==ovs_div-1. ovs_num counts the ovs_ticks issued in the current bit.
  - After OVS ticks in a bit, ovs_cnt holds until the bit wraps, so there are exactly OVS ticks per bit. The remainder cycles (div - OVS*ovs_div) fall at the end of the bit.
  - ovs_cnt and ovs_num clear when bps_cnt wraps.
- Stop: bps_start=0 sampled clears busy and all counters next cycle. Tick outputs are forced low that cycle; a mid-frame abort produces no frame_done.
- Continuous run: frames repeat back to back while bps_start stays high.
- rst has priority over everything: all outputs 0, div = default.

## Timing
- All outputs are registered. Reset values: busy=0, ticks=0, bit_idx=0, cfg_err=0.
- Cycle 0 = first cycle bps_start is sampled high when idle. busy=1 and bps_cnt=0 from cycle 1, so bps_cnt=k at cycle 1+k.
- First mid_tick at cycle 2+(div>>1); first bit_tick at cycle 1+div; subsequent ticks every div cycles.
- First ovs_tick at cycle 1+ovs_div, then every ovs_div cycles, OVS per bit.
- cfg_we and bps_start rising in the same cycle: the write is accepted (busy still 0). Counting starts with the old div; the new div takes effect from the next idle -> run start.
- bps_start low for a single cycle: restart; the next rise is a fresh cycle 0.

## Structure
- Package mb_pkg: DIV_W, OVS and FRAME_BITS defaults, and the function bps_div(clk_frq, bps) returning the reset divisor.
- Sub-module mb_tick_div: counter with compare-to-limit, synchronous clear, enable and registered tick. Instantiated twice, for the bit counter and the oversample counter.
- Frame counter, config register and error logic live in the top module.

## Test plan
- Reset defaults: rst high 3 cycles -> div=434, all outputs 0, busy=0.
- Nominal run: bps_start held high from cycle 0 -> mid_tick at 219, bit_tick at 435, 869, ...; frame_done at 4341 with bit_idx wrapping 9 -> 0.
- Oversampling: div=434 -> ovs_tick at 28, 55, ..., 433 (16 pulses), none at 434; the next bit's first ovs_tick at 462.
- Config rules:
  - write cfg_div=100 while idle -> accepted, bit_tick period 100, ovs_div=6;
  - write cfg_div=20 -> cfg_err pulse, div stays 100;
  - write while busy -> cfg_err pulse, div unchanged.
- Mid-frame abort: drop bps_start at bit_idx=4, cnt=200 -> busy=0, bit_idx=0 next cycle, no frame_done; restart gives a first bit_tick at exactly div+1 cycles.
- Reset mid-run: rst during bit 7 -> all outputs 0 next cycle, div restored to 434, no tick afterward until bps_start re-sampled.

Source files
------------

// File: rtl/mb_bps_gen_pkg.sv
// mb_pkg: shared defaults and reset-divisor helper for the Modbus bit-timing generator.
package mb_pkg;
   localparam int unsigned DIV_W_DEF      = 16;
   localparam int unsigned OVS_DEF        = 16;
   localparam int unsigned FRAME_BITS_DEF = 10;

   function automatic int unsigned bps_div(input int unsigned clk_frq, input int unsigned bps);
      return clk_frq / bps;
   endfunction
endpackage

// File: rtl/mb_tick_div.sv
// mb_tick_div: 0..lim counter with synchronous clear, enable and a registered terminal-count tick.
module mb_tick_div #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] lim,
   output logic [W-1:0] cnt,
   output logic         tick
);
   // tick ignores clr so a terminal count coinciding with a clear still emits its pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         tick <= en && cnt == lim;
         cnt  <= clr ? '0 : !en ? cnt : cnt == lim ? '0 : cnt + W'(1);
      end
   end
endmodule

// File: rtl/mb_bps_gen.sv
// mb_bps_gen: programmable baud/bit-timing generator with oversample, mid-bit and end-of-bit ticks
// plus a frame-position counter for the Modbus UART serialisers.
module mb_bps_gen
   import mb_pkg::*;
#(
   parameter int unsigned CLK_FRQ    = 50_000_000,
   parameter int unsigned BPS_DEF    = 115200,
   parameter int unsigned DIV_W      = DIV_W_DEF,
   parameter int unsigned OVS        = OVS_DEF,
   parameter int unsigned FRAME_BITS = FRAME_BITS_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bps_start,
   input  logic             cfg_we,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             busy,
   output logic             ovs_tick,
   output logic             mid_tick,
   output logic             bit_tick,
   output logic [3:0]       bit_idx,
   output logic             frame_done,
   output logic             cfg_err
);
   localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(bps_div(CLK_FRQ, BPS_DEF));
   localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2 * OVS);
   localparam int unsigned      OVS_SH  = $clog2(OVS);
   localparam logic [5:0]       OVS_N   = 6'(OVS);
   localparam logic [3:0]       LAST    = 4'(FRAME_BITS - 1);

   logic [DIV_W-1:0] div, act_div, ovs_div, bps_lim, ovs_lim, bps_cnt, ovs_cnt;
   logic [5:0]       ovs_num;
   logic             run, wrap, ovs_en, ovs_hit;

   // act_div freezes the divisor for a whole run; config writes only apply at the next start
   assign run     = busy & bps_start;
   assign ovs_div = act_div >> OVS_SH;
   assign bps_lim = act_div - DIV_W'(1);
   assign ovs_lim = ovs_div - DIV_W'(1);
   assign wrap    = run && bps_cnt == bps_lim;
   assign ovs_en  = run && ovs_num != OVS_N;
   assign ovs_hit = ovs_en && ovs_cnt == ovs_lim;

   mb_tick_div #(.W(DIV_W)) u_bit (
      .clk (clk),
      .rst (rst),
      .clr (!run),
      .en  (run),
      .lim (bps_lim),
      .cnt (bps_cnt),
      .tick(bit_tick)
   );

   mb_tick_div #(.W(DIV_W)) u_ovs (
      .clk (clk),
      .rst (rst),
      .clr (!run || wrap),
      .en  (ovs_en),
      .lim (ovs_lim),
      .cnt (ovs_cnt),
      .tick(ovs_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         div        <= DIV_RST;
         act_div    <= DIV_RST;
         busy       <= 1'b0;
         mid_tick   <= 1'b0;
         bit_idx    <= 4'd0;
         frame_done <= 1'b0;
         cfg_err    <= 1'b0;
         ovs_num    <= 6'd0;
      end else begin
         busy <= bps_start;
         if (cfg_we && !busy && cfg_div >= DIV_MIN) div <= cfg_div;
         cfg_err <= cfg_we && (busy || cfg_div < DIV_MIN);
         if (!busy) act_div <= div;
         mid_tick   <= run && bps_cnt == (act_div >> 1);
         frame_done <= wrap && bit_idx == LAST;
         bit_idx    <= !run ? 4'd0 : wrap ? (bit_idx == LAST ? 4'd0 : bit_idx + 4'd1) : bit_idx;
         ovs_num    <= (!run || wrap) ? 6'd0 : ovs_hit ? ovs_num + 6'd1 : ovs_num;
      end
   end
endmodule

// File: tb/tb_mb_bps_gen.sv
// tb_mb_bps_gen: directed self-checking bench for mb_bps_gen at default parameters.
module tb_mb_bps_gen;
   logic        clk = 1'b0;
   logic        rst, bps_start, cfg_we;
   logic [15:0] cfg_div;
   logic        busy, ovs_tick, mid_tick, bit_tick, frame_done, cfg_err;
   logic [3:0]  bit_idx;
   logic [8:0]  act;
   int          checks = 0, fails = 0;

   always #5 clk = ~clk;

   assign act = {busy, ovs_tick, mid_tick, bit_tick, frame_done, bit_idx};

   mb_bps_gen dut (
      .clk       (clk),
      .rst       (rst),
      .bps_start (bps_start),
      .cfg_we    (cfg_we),
      .cfg_div   (cfg_div),
      .busy      (busy),
      .ovs_tick  (ovs_tick),
      .mid_tick  (mid_tick),
      .bit_tick  (bit_tick),
      .bit_idx   (bit_idx),
      .frame_done(frame_done),
      .cfg_err   (cfg_err)
   );

   // Expected {busy, ovs, mid, bit, frame_done, bit_idx} at cycle k (k>=1) of a run with divisor d
   function automatic logic [8:0] exp_vec(input int d, input int k);
      int q, od, idx;
      logic bt, mt, ot;
      od  = d / 16;
      idx = ((k - 1) / d) % 10;
      if (k < 2) return {1'b1, 4'b0000, 4'(idx)};
      q  = (k - 2) % d;
      bt = q == d - 1;
      mt = q == d / 2;
      ot = q < 16 * od && (q + 1) % od == 0;
      return {1'b1, ot, mt, bt, bt && idx == 0, 4'(idx)};
   endfunction

   task automatic test_reset;
      rst = 1'b1; bps_start = 1'b0; cfg_we = 1'b0; cfg_div = 16'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({act, cfg_err} !== 10'd0) $display("FAIL reset_state got=%h want=0", {act, cfg_err});
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({act, cfg_err} !== 10'd0) $display("FAIL reset_idle got=%h want=0", {act, cfg_err});
   endtask

   task automatic test_nominal;
      bps_start = 1'b1;
      for (int k = 1; k <= 4345; k++) begin
         @(negedge clk);
         checks++;
         if (act !== exp_vec(434, k) || cfg_err !== 1'b0) begin
            fails++;
            $display("FAIL nominal k=%0d got=%h want=%h err=%b", k, act, exp_vec(434, k), cfg_err);
         end
      end
      bps_start = 1'b0;
      @(negedge clk);
      checks++;
      if (act !== 9'd0) begin fails++; $display("FAIL nominal_stop got=%h want=0", act); end
   endtask

   task automatic test_ovs_count;
      int n = 0, first = 0;
      logic at_end = 1'b0;
      bps_start = 1'b1;
      for (int k = 1; k <= 470; k++) begin
         @(negedge clk);
         if (k <= 434 && ovs_tick) n++;
         if (k == 434) at_end = ovs_tick;
         if (k > 434 && ovs_tick && first == 0) first = k;
      end
      checks++;
      if (n !== 16) begin fails++; $display("FAIL ovs_per_bit got=%0d want=16", n); end
      checks++;
      if (at_end !== 1'b0) begin fails++; $display("FAIL ovs_at_434 got=%b want=0", at_end); end
      checks++;
      if (first !== 462) begin fails++; $display("FAIL ovs_next_bit got=%0d want=462", first); end
      bps_start = 1'b0;
      @(negedge clk);
      checks++;
      if (act !== 9'd0) begin fails++; $display("FAIL ovs_stop got=%h want=0", act); end
   endtask

   task automatic test_abort;
      bps_start = 1'b1;
      for (int k = 1; k <= 1937; k++) begin
         @(negedge clk);
         checks++;
         if (act !== exp_vec(434, k)) begin
            fails++;
            $display("FAIL abort_run k=%0d got=%h want=%h", k, act, exp_vec(434, k));
         end
      end
      bps_start = 1'b0;
      @(negedge clk);
      checks++;
      if (act !== 9'd0) begin fails++; $display("FAIL abort_stop got=%h want=0", act); end
      bps_start = 1'b1;
      for (int k = 1; k <= 436; k++) begin
         @(negedge clk);
         checks++;
         if (act !== exp_vec(434, k)) begin
            fails++;
            $display("FAIL abort_restart k=%0d got=%h want=%h", k, act, exp_vec(434, k));
         end
      end
      bps_start = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_config;
      cfg_we = 1'b1; cfg_div = 16'd100;
      @(negedge clk);
      cfg_we = 1'b0;
      checks++;
      if (cfg_err !== 1'b0) begin fails++; $display("FAIL cfg_accept_100 got=%b want=0", cfg_err); end
      cfg_we = 1'b1; cfg_div = 16'd20;
      @(negedge clk);
      cfg_we = 1'b0;
      checks++;
      if (cfg_err !== 1'b1) begin fails++; $display("FAIL cfg_reject_20 got=%b want=1", cfg_err); end
      @(negedge clk);
      checks++;
      if (cfg_err !== 1'b0) begin fails++; $display("FAIL cfg_err_pulse got=%b want=0", cfg_err); end
      cfg_we = 1'b1; cfg_div = 16'd31;
      @(negedge clk);
      cfg_we = 1'b0;
      checks++;
      if (cfg_err !== 1'b1) begin fails++; $display("FAIL cfg_reject_31 got=%b want=1", cfg_err); end
      bps_start = 1'b1;
      for (int k = 1; k <= 1010; k++) begin
         @(negedge clk);
         checks++;
         if (act !== exp_vec(100, k) || cfg_err !== (k == 6)) begin
            fails++;
            $display("FAIL cfg_run100 k=%0d got=%h want=%h err=%b", k, act, exp_vec(100, k), cfg_err);
         end
         cfg_we = (k == 5);
         cfg_div = 16'd200;
      end
      bps_start = 1'b0;
      @(negedge clk);
      checks++;
      if (act !== 9'd0) begin fails++; $display("FAIL cfg_stop got=%h want=0", act); end
      bps_start = 1'b1;
      for (int k = 1; k <= 205; k++) begin
         @(negedge clk);
         checks++;
         if (act !== exp_vec(100, k)) begin
            fails++;
            $display("FAIL cfg_busy_write_kept k=%0d got=%h want=%h", k, act, exp_vec(100, k));
         end
      end
      bps_start = 1'b0;
      @(negedge clk);
      cfg_we = 1'b1; cfg_div = 16'd32;
      @(negedge clk);
      cfg_we = 1'b0;
      checks++;
      if (cfg_err !== 1'b0) begin fails++; $display("FAIL cfg_accept_32 got=%b want=0", cfg_err); end
      bps_start = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         checks++;
         if (act !== exp_vec(32, k)) begin
            fails++;
            $display("FAIL cfg_run32 k=%0d got=%h want=%h", k, act, exp_vec(32, k));
         end
      end
      bps_start = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_same_cycle_write;
      cfg_we = 1'b1; cfg_div = 16'd100; bps_start = 1'b1;
      for (int k = 1; k <= 70; k++) begin
         @(negedge clk);
         cfg_we = 1'b0;
         checks++;
         if (act !== exp_vec(32, k) || cfg_err !== 1'b0) begin
            fails++;
            $display("FAIL same_cycle_old_div k=%0d got=%h want=%h err=%b", k, act, exp_vec(32, k), cfg_err);
         end
      end
      bps_start = 1'b0;
      @(negedge clk);
      bps_start = 1'b1;
      for (int k = 1; k <= 205; k++) begin
         @(negedge clk);
         checks++;
         if (act !== exp_vec(100, k)) begin
            fails++;
            $display("FAIL same_cycle_new_div k=%0d got=%h want=%h", k, act, exp_vec(100, k));
         end
      end
      bps_start = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run;
      bps_start = 1'b1;
      for (int k = 1; k <= 731; k++) begin
         @(negedge clk);
         checks++;
         if (act !== exp_vec(100, k)) begin
            fails++;
            $display("FAIL rst_mid_run k=%0d got=%h want=%h", k, act, exp_vec(100, k));
         end
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({act, cfg_err} !== 10'd0) begin fails++; $display("FAIL rst_mid_outputs got=%h want=0", {act, cfg_err}); end
      rst = 1'b0; bps_start = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         checks++;
         if (act !== 9'd0) begin fails++; $display("FAIL rst_idle k=%0d got=%h want=0", k, act); end
      end
      bps_start = 1'b1;
      for (int k = 1; k <= 436; k++) begin
         @(negedge clk);
         checks++;
         if (act !== exp_vec(434, k)) begin
            fails++;
            $display("FAIL rst_div_restored k=%0d got=%h want=%h", k, act, exp_vec(434, k));
         end
      end
      bps_start = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset;
      test_nominal;
      test_ovs_count;
      test_abort;
      test_config;
      test_same_cycle_write;
      test_reset_mid_run;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
